// File: rtl/instruction_encoder.sv
// RV32I field-to-word encoder with LI (LUI+ADDI) expansion over valid/ready.
// Define INSTR_ENC_CHECK_EN to reject immediates that do not fit their format.
`timescale 1ns/1ps
module instruction_encoder #(
    parameter int XLEN              = 32,
    parameter int REG_FILE_DEPTH    = 32,
    parameter int REG_FILE_ADDR_LEN = $clog2(REG_FILE_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         li,
    input  logic [6:0]                   opcode,
    input  logic [REG_FILE_ADDR_LEN-1:0] rd,
    input  logic [REG_FILE_ADDR_LEN-1:0] rs1,
    input  logic [REG_FILE_ADDR_LEN-1:0] rs2,
    input  logic [2:0]                   funct3,
    input  logic [6:0]                   funct7,
    input  logic [XLEN-1:0]              imm,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              instr,
    output logic                         err
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        LI_LO = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic        out_valid_reg, out_valid_next;
    logic [31:0] instr_reg, instr_next;
    logic        err_reg, err_next;
    logic [31:0] pend_reg, pend_next;

    logic [4:0]  rd_f, rs1_f, rs2_f;
    logic [31:0] imm_w;
    logic [31:0] word;
    logic        known;
    logic        range_bad;
    logic [19:0] li_hi;
    logic [11:0] li_lo;
    logic [31:0] lui_word, addi_x0_word, addi_rd_word;
    logic        accept, take;

    assign rd_f  = rd[4:0];
    assign rs1_f = rs1[4:0];
    assign rs2_f = rs2[4:0];
    assign imm_w = imm[31:0];

    // LI splits the constant so that the sign-extended ADDI low part
    // corrects the upper part; hi absorbs the borrow from imm[11].
    assign li_lo        = imm_w[11:0];
    assign li_hi        = imm_w[31:12] + {19'd0, imm_w[11]};
    assign lui_word     = {li_hi, rd_f, OP_LUI};
    assign addi_x0_word = {li_lo, 5'd0, 3'b000, rd_f, OP_IMM};
    assign addi_rd_word = {li_lo, rd_f, 3'b000, rd_f, OP_IMM};

`ifdef INSTR_ENC_CHECK_EN
    logic signed [31:0] simm;
    logic               fit_i, fit_b, fit_j, fit_u;
    assign simm  = $signed(imm_w);
    assign fit_i = (simm >= -32'sd2048) && (simm <= 32'sd2047);
    assign fit_b = !imm_w[0] && (simm >= -32'sd4096) && (simm <= 32'sd4094);
    assign fit_j = !imm_w[0] && (simm >= -32'sd1048576) && (simm <= 32'sd1048574);
    assign fit_u = (imm_w[11:0] == 12'd0);
`endif

    always_comb begin
        word      = '0;
        known     = 1'b1;
        range_bad = 1'b0;
        case (opcode)
            OP_R: begin
                word = {funct7, rs2_f, rs1_f, funct3, rd_f, opcode};
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                // Shift-immediates carry funct7 in the upper bits and a 5-bit shamt.
                if (opcode == OP_IMM && (funct3 == 3'b001 || funct3 == 3'b101))
                    word = {funct7, imm_w[4:0], rs1_f, funct3, rd_f, opcode};
                else
                    word = {imm_w[11:0], rs1_f, funct3, rd_f, opcode};
`ifdef INSTR_ENC_CHECK_EN
                range_bad = !fit_i;
`endif
            end
            OP_STORE: begin
                word = {imm_w[11:5], rs2_f, rs1_f, funct3, imm_w[4:0], opcode};
`ifdef INSTR_ENC_CHECK_EN
                range_bad = !fit_i;
`endif
            end
            OP_BRANCH: begin
                word = {imm_w[12], imm_w[10:5], rs2_f, rs1_f, funct3,
                        imm_w[4:1], imm_w[11], opcode};
`ifdef INSTR_ENC_CHECK_EN
                range_bad = !fit_b;
`endif
            end
            OP_JAL: begin
                word = {imm_w[20], imm_w[10:1], imm_w[11], imm_w[19:12], rd_f, opcode};
`ifdef INSTR_ENC_CHECK_EN
                range_bad = !fit_j;
`endif
            end
            OP_LUI, OP_AUIPC: begin
                word = {imm_w[31:12], rd_f, opcode};
`ifdef INSTR_ENC_CHECK_EN
                range_bad = !fit_u;
`endif
            end
            default: begin
                known = 1'b0;
            end
        endcase
    end

    assign in_ready = (state_reg == IDLE) && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;
    assign take     = out_valid_reg && out_ready;

    always_comb begin
        state_next     = state_reg;
        out_valid_next = out_valid_reg;
        instr_next     = instr_reg;
        err_next       = 1'b0;
        pend_next      = pend_reg;
        case (state_reg)
            IDLE: begin
                // Acceptance implies any held word is consumed at this same edge.
                if (accept) begin
                    if (li) begin
                        out_valid_next = 1'b1;
                        if (li_hi == 20'd0) begin
                            instr_next = addi_x0_word;
                        end else begin
                            instr_next = lui_word;
                            pend_next  = addi_rd_word;
                            state_next = LI_LO;
                        end
                    end else if (!known || range_bad) begin
                        out_valid_next = 1'b0;
                        err_next       = 1'b1;
                    end else begin
                        out_valid_next = 1'b1;
                        instr_next     = word;
                    end
                end else if (take) begin
                    out_valid_next = 1'b0;
                end
            end
            LI_LO: begin
                if (take) begin
                    instr_next = pend_reg;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            instr_reg     <= '0;
            err_reg       <= 1'b0;
            pend_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= out_valid_next;
            instr_reg     <= instr_next;
            err_reg       <= err_next;
            pend_reg      <= pend_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign instr     = XLEN'(instr_reg);
    assign err       = err_reg;

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: directed vectors plus randomized
// requests checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_instruction_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        li;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;

    logic        rand_mode = 1'b0;
    logic        rand_ready = 1'b1;
    logic        dir_ready = 1'b1;
    assign out_ready = rand_mode ? rand_ready : dir_ready;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        is_err;
        logic [31:0] word;
    } exp_t;
    exp_t exp_q[$];

    instruction_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .li        (li),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rand_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_t e;
        e.is_err = 1'b0;
        e.word   = w;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.word   = '0;
        exp_q.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every output handshake or err pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_word: got %h expected nothing", instr);
                end else begin
                    if (exp_q[0].is_err || instr !== exp_q[0].word) begin
                        n_fail++;
                        $display("FAIL out_word: got %h expected %s%h", instr,
                                 exp_q[0].is_err ? "err " : "", exp_q[0].word);
                    end else begin
                        $display("word %h", instr);
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (err) begin
                n_cmp++;
                if (exp_q.size() == 0 || !exp_q[0].is_err) begin
                    n_fail++;
                    $display("FAIL err_pulse: got err expected %s",
                             exp_q.size() == 0 ? "nothing" : "word");
                end else begin
                    $display("err pulse");
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
    end

    // Reference model: places each field at its bit position with plain arithmetic.
    task automatic expect_req(input bit l, input logic [6:0] op, input logic [4:0] d,
                              input logic [4:0] s1, input logic [4:0] s2,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] im);
        logic [31:0] dd, ss1, ss2, ff3, ff7, oo, w, lo, hi;
        int si;
        bit bad;
        dd = 32'(d); ss1 = 32'(s1); ss2 = 32'(s2);
        ff3 = 32'(f3); ff7 = 32'(f7); oo = 32'(op);
        si = int'(im);
        bad = 1'b0;
        w = '0;
        if (l) begin
            lo = im & 32'hFFF;
            hi = ((im + 32'h800) >> 12) & 32'hFFFFF;
            if (hi == 0) begin
                push_word((lo << 20) | (dd << 7) | 32'h13);
            end else begin
                push_word((hi << 12) | (dd << 7) | 32'h37);
                push_word((lo << 20) | (dd << 15) | (dd << 7) | 32'h13);
            end
            return;
        end
        case (op)
            7'h33: w = (ff7 << 25) | (ss2 << 20) | (ss1 << 15) | (ff3 << 12) | (dd << 7) | oo;
            7'h13, 7'h03, 7'h67: begin
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5))
                    w = (ff7 << 25) | ((im & 32'h1F) << 20) | (ss1 << 15) | (ff3 << 12) | (dd << 7) | oo;
                else
                    w = ((im & 32'hFFF) << 20) | (ss1 << 15) | (ff3 << 12) | (dd << 7) | oo;
`ifdef INSTR_ENC_CHECK_EN
                bad = (si < -2048) || (si > 2047);
`endif
            end
            7'h23: begin
                w = (((im >> 5) & 32'h7F) << 25) | (ss2 << 20) | (ss1 << 15) | (ff3 << 12)
                    | ((im & 32'h1F) << 7) | oo;
`ifdef INSTR_ENC_CHECK_EN
                bad = (si < -2048) || (si > 2047);
`endif
            end
            7'h63: begin
                w = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | (ss2 << 20)
                    | (ss1 << 15) | (ff3 << 12) | (((im >> 1) & 32'hF) << 8)
                    | (((im >> 11) & 1) << 7) | oo;
`ifdef INSTR_ENC_CHECK_EN
                bad = (im[0] != 1'b0) || (si < -4096) || (si > 4094);
`endif
            end
            7'h6F: begin
                w = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                    | (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hFF) << 12) | (dd << 7) | oo;
`ifdef INSTR_ENC_CHECK_EN
                bad = (im[0] != 1'b0) || (si < -1048576) || (si > 1048574);
`endif
            end
            7'h37, 7'h17: begin
                w = (im & 32'hFFFFF000) | (dd << 7) | oo;
`ifdef INSTR_ENC_CHECK_EN
                bad = ((im & 32'hFFF) != 0);
`endif
            end
            default: bad = 1'b1;
        endcase
        if (bad) push_err();
        else push_word(w);
    endtask

    task automatic set_req(input bit l, input logic [6:0] op, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2,
                           input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] im);
        li = l; opcode = op; rd = d; rs1 = s1; rs2 = s2;
        funct3 = f3; funct7 = f7; imm = im;
    endtask

    // Holds in_valid until the request is accepted; returns #1 after that edge.
    task automatic send(input bit l, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] im);
        bit ok;
        set_req(l, op, d, s1, s2, f3, f7, im);
        in_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got no in_ready expected acceptance");
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 300 && (exp_q.size() != 0 || out_valid); c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic bit is_known(input logic [6:0] op);
        return op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h23
            || op == 7'h63 || op == 7'h6F || op == 7'h37 || op == 7'h17;
    endfunction

    function automatic logic [31:0] rand_imm();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0: v = $urandom();
            1: v = 32'(int'($urandom_range(0, 4095)) - 2048);
            2: v = 32'(int'($urandom_range(0, 8191)) - 4096) & 32'hFFFFFFFE;
            3: v = 32'(int'($urandom_range(0, 2097151)) - 1048576) & 32'hFFFFFFFE;
            default: v = $urandom() & 32'hFFFFF000;
        endcase
        return v;
    endfunction

    logic [6:0] known_ops [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17};

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        set_req(1'b0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_instr", instr, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Test-plan vectors with literal expected words.
        push_word(32'h002081B3);
        send(1'b0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        check("latency_add", {31'd0, out_valid}, 32'd1);
        push_word(32'hFFF00093);
        send(1'b0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
        push_word(32'h001000EF);
        send(1'b0, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800);
        push_word(32'h123462B7);
        push_word(32'hFFF28293);
        send(1'b1, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
        check("li_in_ready_low", {31'd0, in_ready}, 32'd0);
        push_word(32'h7FF00313);
        send(1'b1, 7'h00, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'h000007FF);
        drain();

        // Backpressure: word held, then replaced in the cycle it is taken.
        dir_ready = 1'b0;
        push_word(32'h002081B3);
        send(1'b0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_instr", instr, 32'h002081B3);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        push_word(32'hFFF00093);
        set_req(1'b0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
        in_valid = 1'b1;
        dir_ready = 1'b1;
        @(negedge clk);
        check("same_cycle_ready", {30'd0, in_ready, out_valid}, 32'd3);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("same_cycle_load", instr, 32'hFFF00093);
        drain();

        // Unknown opcode: err for exactly one cycle, no word.
        push_err();
        send(1'b0, 7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        check("unknown_err", {30'd0, err, out_valid}, 32'd2);
        @(posedge clk);
        #1;
        check("unknown_err_clear", {30'd0, err, out_valid}, 32'd0);
`ifdef INSTR_ENC_CHECK_EN
        push_err();
        send(1'b0, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h00000003);
        check("branch_misaligned", {30'd0, err, out_valid}, 32'd2);
`endif
        drain();

        // Reset while the ADDI half of an LI is pending.
        dir_ready = 1'b0;
        send(1'b1, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
        check("li_lui_pending", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_reset_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        dir_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("no_addi_after_reset", {31'd0, out_valid}, 32'd0);

        // Randomized traffic with random backpressure.
        rand_mode = 1'b1;
        for (int n = 0; n < 400; n++) begin
            bit          l;
            logic [6:0]  op;
            logic [4:0]  d, s1, s2;
            logic [2:0]  f3;
            logic [6:0]  f7;
            logic [31:0] im;
            l  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) begin
                op = 7'($urandom());
                while (is_known(op)) op = 7'($urandom());
            end else begin
                op = known_ops[$urandom_range(0, 8)];
            end
            d  = 5'($urandom());
            s1 = 5'($urandom());
            s2 = 5'($urandom());
            f3 = 3'($urandom());
            f7 = 7'($urandom());
            im = rand_imm();
            expect_req(l, op, d, s1, s2, f3, f7, im);
            send(l, op, d, s1, s2, f3, f7, im);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_mode = 1'b0;
        dir_ready = 1'b1;
        drain();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Field-to-word encoder for RV32I; the inverse of the instruction decoder.
- Accepts opcode, register addresses, funct3/funct7 and a 32-bit immediate over a valid/ready handshake.
- Emits one registered 32-bit instruction word per accepted request. The LI pseudo-instruction expands to two words.
- Used by the test-program generator and the boot-ROM builder to feed instruction memory and the decoder.

Parameters:
- XLEN, 32, instruction/immediate width.
- REG_FILE_DEPTH, 32, number of architectural registers.
- REG_FILE_ADDR_LEN, $clog2(REG_FILE_DEPTH), register address width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid & in_ready.
- li  input  1  1 = LI pseudo-op: rd := imm. opcode, funct and rs fields are ignored.
- opcode  input  7  RV32I major opcode.
- rd  input  REG_FILE_ADDR_LEN  destination register.
- rs1  input  REG_FILE_ADDR_LEN  source register 1.
- rs2  input  REG_FILE_ADDR_LEN  source register 2.
- funct3  input  3  funct3 field.
- funct7  input  7  funct7 field.
- imm  input  XLEN  signed immediate, byte offset for branch/JAL.
- out_valid  output  1  instr valid.
- out_ready  input  1  consumer accepts instr.
- instr  output  XLEN  encoded instruction word.
- err  output  1  one-cycle pulse: request accepted but dropped.

Behaviour:
- Reset: out_valid=0, instr=0, err=0, state=IDLE. in_ready=1 after reset.
- in_ready = (state==IDLE) & (!out_valid | out_ready). A new word may load in the same cycle the old one is taken.
- Latency: request accepted at cycle N → instr/out_valid at N+1. instr is held stable while out_valid & !out_ready.
- Encoding by opcode:
  - OP 0110011: R-type.
  - OP_IMM 0010011, LOAD 0000011, JALR 1100111: I-type with imm[11:0]. For OP_IMM with funct3 001/101, bits[31:25]=funct7 and bits[24:20]=imm[4:0].
  - STORE 0100011: S-type, imm[11:5]/imm[4:0].
  - BRANCH 1100011: B-type, imm[12|10:5|4:1|11].
  - JAL 1101111: J-type, imm[20|10:1|11|19:12].
  - LUI 0110111, AUIPC 0010111: U-type, imm[31:12].
  - Unused fields are zero.
- Unknown opcode: request consumed, no output word, err=1 for one cycle.
- LI expansion:
  - lo = imm[11:0]; hi = imm[31:12] + imm[11] (mod 2^20).
  - hi==0 → single word ADDI rd,x0,lo.
  - Otherwise emit LUI rd,hi, then ADDI rd,rd,lo.
- FSM:
  - IDLE → LI_LO on accepting an LI with hi≠0.
  - LI_LO: loads the ADDI word when the LUI word is handshaken, then → IDLE.
  - in_ready=0 in LI_LO.
- rd=0 is encoded as given; no special case.
- Reset mid-operation (any state, including LI_LO): pending words are dropped; out_valid=0 the next cycle.

Optional Feature:
- Macro: INSTR_ENC_CHECK_EN.
- Defined: the request is dropped with an err pulse and no output when any of these holds:
  - BRANCH with imm[0]≠0 or imm outside [-4096, 4094].
  - JAL with imm[0]≠0 or imm outside [-2^20, 2^20-2].
  - I/S-type with imm outside [-2048, 2047].
  - U-type with imm[11:0]≠0.
- Undefined: no checks; out-of-range bits are silently truncated and err fires only for unknown opcodes.

Test Plan:
- add x3,x1,x2: opcode=0x33, rd=3, rs1=1, rs2=2, f3=0, f7=0 → instr=0x002081B3, out_valid one cycle after acceptance.
- addi x1,x0,-1: opcode=0x13, rd=1, imm=0xFFFFFFFF → 0xFFF00093. jal x1,+2048: imm=0x800 → 0x001000EF.
- li x5,0x12345FFF → 0x123462B7 then 0xFFF28293. in_ready=0 between the two words. li x6,0x7FF → single word 0x7FF00313.
- Backpressure: out_ready=0 for 3 cycles with a word pending → instr stable, in_ready=0. On out_ready=1 with in_valid=1, the next word loads the same cycle.
- opcode=0x7F → err pulse 1 cycle, out_valid stays 0. With INSTR_ENC_CHECK_EN: BRANCH imm=0x3 → err, no word.
- rst asserted in LI_LO → out_valid=0 the next cycle, ADDI word never emitted, in_ready=1.
